// File: rtl/enemy_pool_if.sv
// enemy_pool_if
//   Bundles the enemy pool's game-logic and pixel-lookup signals.
//   master: game logic / scan path side (drives requests, reads results).
//   slave : enemy_pool side.
//   Inputs to the pool : en_i, frame_tick_i, rand_i, hit_i, req_x_i, req_y_i
//   Outputs of the pool: pix_vali_o, pix_idx_o, bram_addr_o, spawn_o,
//                        spawn_idx_o, destroy_mask_o, escape_mask_o,
//                        alive_o, active_cnt_o
interface enemy_pool_if #(
    parameter int SLOT_NUM   = 8,
    parameter int SLOT_IDX_W = 3,
    parameter int POS_W      = 10,
    parameter int ADDR_W     = 12
);
    logic                  en_i;
    logic                  frame_tick_i;
    logic [15:0]           rand_i;
    logic [SLOT_NUM-1:0]   hit_i;
    logic [POS_W-1:0]      req_x_i;
    logic [POS_W-1:0]      req_y_i;

    logic                  pix_vali_o;
    logic [SLOT_IDX_W-1:0] pix_idx_o;
    logic [ADDR_W-1:0]     bram_addr_o;
    logic                  spawn_o;
    logic [SLOT_IDX_W-1:0] spawn_idx_o;
    logic [SLOT_NUM-1:0]   destroy_mask_o;
    logic [SLOT_NUM-1:0]   escape_mask_o;
    logic [SLOT_NUM-1:0]   alive_o;
    logic [SLOT_IDX_W:0]   active_cnt_o;

    modport master (
        output en_i, frame_tick_i, rand_i, hit_i, req_x_i, req_y_i,
        input  pix_vali_o, pix_idx_o, bram_addr_o, spawn_o, spawn_idx_o,
               destroy_mask_o, escape_mask_o, alive_o, active_cnt_o
    );

    modport slave (
        input  en_i, frame_tick_i, rand_i, hit_i, req_x_i, req_y_i,
        output pix_vali_o, pix_idx_o, bram_addr_o, spawn_o, spawn_idx_o,
               destroy_mask_o, escape_mask_o, alive_o, active_cnt_o
    );
endinterface

// File: rtl/enemy_pool.sv
// enemy_pool
//   Pool of SLOT_NUM enemy slots (IDLE / ALIVE / EXPLODE). Spawns periodically
//   into the lowest free slot, moves slots down once per frame tick, handles
//   hits and explosions, and answers per-pixel lookups with a registered
//   sprite/explosion BRAM address (one cycle latency).
//   Ports: clk_run (system clock), rst_n (async active-low reset),
//          bus (enemy_pool_if.slave: game-logic and lookup signals).
//   Vertical positions are kept as fixed_y = real_y + Y_SIZE so they never
//   go negative while a sprite enters from the top edge.
module enemy_pool #(
    parameter int SLOT_NUM       = 8,
    parameter int SLOT_IDX_W     = 3,
    parameter int H_DISP         = 640,
    parameter int V_DISP         = 480,
    parameter int X_SIZE         = 50,
    parameter int Y_SIZE         = 40,
    parameter int POS_W          = 10,
    parameter int SPAWN_PERIOD   = 1000,
    parameter int SPAWN_CNT_W    = 10,
    parameter int HP_INIT        = 3,
    parameter int HP_W           = 2,
    parameter int SPEED_SLOW     = 1,
    parameter int SPEED_FAST     = 3,
    parameter int EXPLODE_FRAMES = 8,
    parameter int ADDR_W         = 12
) (
    input logic         clk_run,
    input logic         rst_n,
    enemy_pool_if.slave bus
);
    localparam int PW1      = POS_W + 1;
    localparam int CNT_W    = SLOT_IDX_W + 1;
    localparam int EXP_W    = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
    localparam int FY_LIMIT = V_DISP + Y_SIZE;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ALIVE = 2'd1, S_EXPLODE = 2'd2} slot_state_e;

    slot_state_e           state_q [SLOT_NUM];
    slot_state_e           state_d [SLOT_NUM];
    logic [POS_W-1:0]      x_q     [SLOT_NUM];
    logic [POS_W-1:0]      x_d     [SLOT_NUM];
    logic [POS_W-1:0]      fy_q    [SLOT_NUM];
    logic [POS_W-1:0]      fy_d    [SLOT_NUM];
    logic [HP_W-1:0]       hp_q    [SLOT_NUM];
    logic [HP_W-1:0]       hp_d    [SLOT_NUM];
    logic [EXP_W-1:0]      exp_q   [SLOT_NUM];
    logic [EXP_W-1:0]      exp_d   [SLOT_NUM];
    logic [SLOT_NUM-1:0]   fast_q, fast_d;

    logic [SPAWN_CNT_W-1:0] cnt_q, cnt_d;
    logic                   pend_q, pend_d;

    logic                  spawn_q, spawn_d;
    logic [SLOT_IDX_W-1:0] spawn_idx_q, spawn_idx_d;
    logic [SLOT_NUM-1:0]   destroy_q, destroy_d;
    logic [SLOT_NUM-1:0]   escape_q, escape_d;
    logic                  pix_vali_q, pix_vali_d;
    logic [SLOT_IDX_W-1:0] pix_idx_q, pix_idx_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;

    logic                  free_found;
    logic [SLOT_IDX_W-1:0] free_idx;
    logic                  spawn_now;
    logic [POS_W-1:0]      rand_x, spawn_x;
    logic [PW1-1:0]        fy_next;
    logic [CNT_W-1:0]      active_cnt;
    logic [SLOT_NUM-1:0]   alive_w;
    logic                  unused_rand;

    // Upper rand bits between the x field and the speed bit carry no meaning.
    assign unused_rand = ^bus.rand_i[14:POS_W];

    assign rand_x  = bus.rand_i[POS_W-1:0];
    assign spawn_x = (rand_x > POS_W'(H_DISP - X_SIZE)) ? POS_W'(H_DISP - X_SIZE) : rand_x;

    // Spawn counter, pending request and lowest-free-slot search.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        free_found  = 1'b0;
        free_idx    = '0;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        // Scan downwards so the lowest IDLE index is the last one written.
        for (int k = SLOT_NUM - 1; k >= 0; k--) begin
            if (state_q[k] == S_IDLE) begin
                free_found = 1'b1;
                free_idx   = SLOT_IDX_W'(k);
            end
        end
        spawn_now = bus.en_i && pend_q && free_found;
        if (!bus.en_i) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end else if (cnt_q == SPAWN_CNT_W'(SPAWN_PERIOD - 1)) begin
            // A wrap always leaves a request pending; requests never stack.
            cnt_d  = '0;
            pend_d = 1'b1;
        end else begin
            cnt_d = cnt_q + SPAWN_CNT_W'(1);
            if (spawn_now) pend_d = 1'b0;
        end
        spawn_d     = spawn_now;
        spawn_idx_d = spawn_now ? free_idx : '0;
    end

    // Per-slot next state: spawn, hit, motion, escape and explosion.
    always_comb begin
        destroy_d = '0;
        escape_d  = '0;
        fast_d    = fast_q;
        fy_next   = '0;
        for (int k = 0; k < SLOT_NUM; k++) begin
            state_d[k] = state_q[k];
            x_d[k]     = x_q[k];
            fy_d[k]    = fy_q[k];
            hp_d[k]    = hp_q[k];
            exp_d[k]   = exp_q[k];
            fy_next    = PW1'(fy_q[k]) + (fast_q[k] ? PW1'(SPEED_FAST) : PW1'(SPEED_SLOW));
            case (state_q[k])
                S_IDLE: begin
                    if (spawn_now && free_idx == SLOT_IDX_W'(k)) begin
                        state_d[k] = S_ALIVE;
                        hp_d[k]    = HP_W'(HP_INIT);
                        fy_d[k]    = '0;
                        x_d[k]     = spawn_x;
                        fast_d[k]  = bus.rand_i[15];
                    end
                end
                S_ALIVE: begin
                    if (bus.hit_i[k] && hp_q[k] == HP_W'(1)) begin
                        // A kill outranks an escape in the same frame.
                        state_d[k]   = S_EXPLODE;
                        hp_d[k]      = '0;
                        exp_d[k]     = '0;
                        destroy_d[k] = 1'b1;
                    end else begin
                        if (bus.hit_i[k]) hp_d[k] = hp_q[k] - HP_W'(1);
                        if (bus.frame_tick_i) begin
                            if (fy_next >= PW1'(FY_LIMIT)) begin
                                state_d[k]  = S_IDLE;
                                escape_d[k] = 1'b1;
                            end else begin
                                fy_d[k] = fy_next[POS_W-1:0];
                            end
                        end
                    end
                end
                S_EXPLODE: begin
                    if (bus.frame_tick_i) begin
                        if (exp_q[k] == EXP_W'(EXPLODE_FRAMES - 1)) state_d[k] = S_IDLE;
                        else exp_d[k] = exp_q[k] + EXP_W'(1);
                    end
                end
                default: state_d[k] = S_IDLE;
            endcase
        end
    end

    // Pixel lookup: lowest covering slot wins; explosion frames sit in the
    // upper half of the BRAM.
    logic [PW1-1:0] rx, ry, xk, fyk, sel_dx, sel_dy;
    logic           sel_exp;

    always_comb begin
        rx         = PW1'(bus.req_x_i);
        ry         = PW1'(bus.req_y_i) + PW1'(Y_SIZE);
        xk         = '0;
        fyk        = '0;
        pix_vali_d = 1'b0;
        pix_idx_d  = '0;
        sel_dx     = '0;
        sel_dy     = '0;
        sel_exp    = 1'b0;
        for (int k = SLOT_NUM - 1; k >= 0; k--) begin
            xk  = PW1'(x_q[k]);
            fyk = PW1'(fy_q[k]);
            if (state_q[k] != S_IDLE && xk <= rx && rx < xk + PW1'(X_SIZE) &&
                fyk <= ry && ry < fyk + PW1'(Y_SIZE)) begin
                pix_vali_d = 1'b1;
                pix_idx_d  = SLOT_IDX_W'(k);
                sel_dx     = rx - xk;
                sel_dy     = ry - fyk;
                sel_exp    = (state_q[k] == S_EXPLODE);
            end
        end
        addr_d = ADDR_W'(sel_dy) * ADDR_W'(X_SIZE) + ADDR_W'(sel_dx) +
                 (sel_exp ? ADDR_W'(X_SIZE * Y_SIZE) : ADDR_W'(0));
    end

    always_ff @(posedge clk_run or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the slot arrays are small register files holding live game
            // state, so they are reset explicitly rather than left undefined.
            for (int k = 0; k < SLOT_NUM; k++) begin
                state_q[k] <= S_IDLE;
                x_q[k]     <= '0;
                fy_q[k]    <= '0;
                hp_q[k]    <= '0;
                exp_q[k]   <= '0;
            end
            fast_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            spawn_q     <= 1'b0;
            spawn_idx_q <= '0;
            destroy_q   <= '0;
            escape_q    <= '0;
            pix_vali_q  <= 1'b0;
            pix_idx_q   <= '0;
            addr_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values regardless of statement order.
            for (int k = 0; k < SLOT_NUM; k++) begin
                state_q[k] <= state_d[k];
                x_q[k]     <= x_d[k];
                fy_q[k]    <= fy_d[k];
                hp_q[k]    <= hp_d[k];
                exp_q[k]   <= exp_d[k];
            end
            fast_q      <= fast_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            spawn_q     <= spawn_d;
            spawn_idx_q <= spawn_idx_d;
            destroy_q   <= destroy_d;
            escape_q    <= escape_d;
            pix_vali_q  <= pix_vali_d;
            pix_idx_q   <= pix_idx_d;
            addr_q      <= addr_d;
        end
    end

    always_comb begin
        active_cnt = '0;
        alive_w    = '0;
        for (int k = 0; k < SLOT_NUM; k++) begin
            alive_w[k] = (state_q[k] == S_ALIVE);
            if (state_q[k] != S_IDLE) active_cnt = active_cnt + CNT_W'(1);
        end
    end

    assign bus.pix_vali_o     = pix_vali_q;
    assign bus.pix_idx_o      = pix_idx_q;
    assign bus.bram_addr_o    = addr_q;
    assign bus.spawn_o        = spawn_q;
    assign bus.spawn_idx_o    = spawn_idx_q;
    assign bus.destroy_mask_o = destroy_q;
    assign bus.escape_mask_o  = escape_q;
    assign bus.alive_o        = alive_w;
    assign bus.active_cnt_o   = active_cnt;
endmodule

// File: tb/tb_enemy_pool.sv
// tb_enemy_pool
//   Directed bench for enemy_pool with SPAWN_PERIOD shortened to 4.
//   Scenarios: reset, spawn fill, slot reuse, motion/escape, kill vs escape,
//   pixel lookup, x clipping and asynchronous reset mid-explosion.
module tb_enemy_pool;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    enemy_pool_if #(.SLOT_NUM(8), .SLOT_IDX_W(3), .POS_W(10), .ADDR_W(12)) bus ();

    enemy_pool #(.SPAWN_PERIOD(4)) dut (
        .clk_run (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.en_i = 1'b0; bus.frame_tick_i = 1'b0; bus.rand_i = '0;
        bus.hit_i = '0; bus.req_x_i = '0; bus.req_y_i = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
    endtask

    // Enables spawning and waits (bounded) for the next spawn pulse.
    task automatic spawn_one(input logic [15:0] r, output bit got, output int idx, output int cyc);
        bus.rand_i = r;
        bus.en_i   = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            step();
            cyc++;
            if (bus.spawn_o === 1'b1) got = 1'b1;
        end
        idx = int'(bus.spawn_idx_o);
    endtask

    task automatic frame_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick_i = 1'b1; step();
            bus.frame_tick_i = 1'b0; step();
        end
    endtask

    task automatic hits(input logic [7:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            bus.hit_i = mask; step();
        end
        bus.hit_i = '0;
    endtask

    task automatic probe(input int x, input int y);
        bus.req_x_i = 10'(x);
        bus.req_y_i = 10'(y);
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (bus.active_cnt_o !== 4'd0) begin n_err++; $display("FAIL reset_active: got %0d want 0", bus.active_cnt_o); end
        n_cmp++; if (bus.alive_o !== 8'h00) begin n_err++; $display("FAIL reset_alive: got %h want 00", bus.alive_o); end
        n_cmp++; if ({bus.spawn_o, bus.spawn_idx_o, bus.destroy_mask_o, bus.escape_mask_o} !== 20'd0) begin
            n_err++; $display("FAIL reset_pulses: got %h want 0", {bus.spawn_o, bus.spawn_idx_o, bus.destroy_mask_o, bus.escape_mask_o}); end
        n_cmp++; if ({bus.pix_vali_o, bus.pix_idx_o, bus.bram_addr_o} !== 16'd0) begin
            n_err++; $display("FAIL reset_lookup: got %h want 0", {bus.pix_vali_o, bus.pix_idx_o, bus.bram_addr_o}); end
    endtask

    task automatic test_spawn_fill();
        bit got; int idx; int cyc; bit extra;
        for (int i = 0; i < 8; i++) begin
            spawn_one(16'h0000, got, idx, cyc);
            n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL fill_spawn%0d: got no pulse want pulse", i); end
            n_cmp++; if (idx != i) begin n_err++; $display("FAIL fill_idx%0d: got %0d want %0d", i, idx, i); end
            n_cmp++; if (cyc != ((i == 0) ? 5 : 4)) begin n_err++; $display("FAIL fill_gap%0d: got %0d want %0d", i, cyc, (i == 0) ? 5 : 4); end
            n_cmp++; if (bus.active_cnt_o !== 4'(i + 1)) begin n_err++; $display("FAIL fill_active%0d: got %0d want %0d", i, bus.active_cnt_o, i + 1); end
        end
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.spawn_o === 1'b1) extra = 1'b1;
        end
        n_cmp++; if (extra !== 1'b0) begin n_err++; $display("FAIL fill_full_nospawn: got spawn want none"); end
        n_cmp++; if (bus.alive_o !== 8'hFF) begin n_err++; $display("FAIL fill_alive: got %h want ff", bus.alive_o); end
    endtask

    task automatic test_slot_reuse();
        hits(8'h08, 3);
        n_cmp++; if (bus.destroy_mask_o !== 8'h08) begin n_err++; $display("FAIL reuse_destroy: got %h want 08", bus.destroy_mask_o); end
        n_cmp++; if (bus.alive_o !== 8'hF7) begin n_err++; $display("FAIL reuse_alive: got %h want f7", bus.alive_o); end
        n_cmp++; if (bus.active_cnt_o !== 4'd8) begin n_err++; $display("FAIL reuse_active_exp: got %0d want 8", bus.active_cnt_o); end
        frame_ticks(7);
        bus.frame_tick_i = 1'b1; step(); bus.frame_tick_i = 1'b0;
        n_cmp++; if (bus.active_cnt_o !== 4'd7) begin n_err++; $display("FAIL reuse_freed: got %0d want 7", bus.active_cnt_o); end
        n_cmp++; if (bus.spawn_o !== 1'b0) begin n_err++; $display("FAIL reuse_early: got %b want 0", bus.spawn_o); end
        step();
        n_cmp++; if (bus.spawn_o !== 1'b1) begin n_err++; $display("FAIL reuse_spawn: got %b want 1", bus.spawn_o); end
        n_cmp++; if (bus.spawn_idx_o !== 3'd3) begin n_err++; $display("FAIL reuse_idx: got %0d want 3", bus.spawn_idx_o); end
        n_cmp++; if (bus.active_cnt_o !== 4'd8) begin n_err++; $display("FAIL reuse_refill: got %0d want 8", bus.active_cnt_o); end
    endtask

    task automatic test_motion_escape();
        bit got; int idx; int cyc;
        apply_reset();
        spawn_one(16'h0000, got, idx, cyc);
        bus.en_i = 1'b0;
        n_cmp++; if (!got || idx != 0) begin n_err++; $display("FAIL motion_spawn: got %0b/%0d want 1/0", got, idx); end
        frame_ticks(519);
        n_cmp++; if (bus.alive_o !== 8'h01) begin n_err++; $display("FAIL motion_alive519: got %h want 01", bus.alive_o); end
        probe(0, 479);
        n_cmp++; if (bus.pix_vali_o !== 1'b1 || bus.bram_addr_o !== 12'd0) begin
            n_err++; $display("FAIL motion_fy519: got %b/%0d want 1/0", bus.pix_vali_o, bus.bram_addr_o); end
        probe(0, 478);
        n_cmp++; if (bus.pix_vali_o !== 1'b0) begin n_err++; $display("FAIL motion_above: got %b want 0", bus.pix_vali_o); end
        bus.frame_tick_i = 1'b1; step(); bus.frame_tick_i = 1'b0;
        n_cmp++; if (bus.escape_mask_o !== 8'h01) begin n_err++; $display("FAIL escape_mask: got %h want 01", bus.escape_mask_o); end
        n_cmp++; if (bus.destroy_mask_o !== 8'h00) begin n_err++; $display("FAIL escape_nodestroy: got %h want 00", bus.destroy_mask_o); end
        n_cmp++; if (bus.active_cnt_o !== 4'd0 || bus.alive_o !== 8'h00) begin
            n_err++; $display("FAIL escape_idle: got %0d/%h want 0/00", bus.active_cnt_o, bus.alive_o); end
        step();
        n_cmp++; if (bus.escape_mask_o !== 8'h00) begin n_err++; $display("FAIL escape_pulse: got %h want 00", bus.escape_mask_o); end
    endtask

    task automatic test_kill_vs_escape();
        bit got; int idx; int cyc;
        apply_reset();
        spawn_one(16'h8000, got, idx, cyc);
        bus.en_i = 1'b0;
        frame_ticks(173);
        probe(0, 479);
        n_cmp++; if (bus.pix_vali_o !== 1'b1) begin n_err++; $display("FAIL kve_fy519: got %b want 1", bus.pix_vali_o); end
        hits(8'h01, 2);
        n_cmp++; if (bus.alive_o !== 8'h01) begin n_err++; $display("FAIL kve_hp1: got %h want 01", bus.alive_o); end
        bus.hit_i = 8'h01; bus.frame_tick_i = 1'b1; step();
        bus.hit_i = '0;    bus.frame_tick_i = 1'b0;
        n_cmp++; if (bus.destroy_mask_o !== 8'h01) begin n_err++; $display("FAIL kve_destroy: got %h want 01", bus.destroy_mask_o); end
        n_cmp++; if (bus.escape_mask_o !== 8'h00) begin n_err++; $display("FAIL kve_escape: got %h want 00", bus.escape_mask_o); end
        n_cmp++; if (bus.alive_o !== 8'h00 || bus.active_cnt_o !== 4'd1) begin
            n_err++; $display("FAIL kve_explode: got %h/%0d want 00/1", bus.alive_o, bus.active_cnt_o); end
        probe(0, 479);
        n_cmp++; if (bus.bram_addr_o !== 12'd2000) begin n_err++; $display("FAIL kve_exp_addr: got %0d want 2000", bus.bram_addr_o); end
    endtask

    task automatic test_lookup();
        bit got; int idx; int cyc;
        apply_reset();
        spawn_one(16'd100, got, idx, cyc);
        spawn_one(16'd120, got, idx, cyc);
        bus.en_i = 1'b0;
        n_cmp++; if (!got || idx != 1) begin n_err++; $display("FAIL look_spawn1: got %0b/%0d want 1/1", got, idx); end
        frame_ticks(40);
        probe(130, 10);
        n_cmp++; if (bus.pix_vali_o !== 1'b1 || bus.pix_idx_o !== 3'd0 || bus.bram_addr_o !== 12'd530) begin
            n_err++; $display("FAIL look_overlap: got %b/%0d/%0d want 1/0/530", bus.pix_vali_o, bus.pix_idx_o, bus.bram_addr_o); end
        probe(160, 10);
        n_cmp++; if (bus.pix_vali_o !== 1'b1 || bus.pix_idx_o !== 3'd1 || bus.bram_addr_o !== 12'd540) begin
            n_err++; $display("FAIL look_slot1: got %b/%0d/%0d want 1/1/540", bus.pix_vali_o, bus.pix_idx_o, bus.bram_addr_o); end
        probe(130, 40);
        n_cmp++; if ({bus.pix_vali_o, bus.pix_idx_o, bus.bram_addr_o} !== 16'd0) begin
            n_err++; $display("FAIL look_miss: got %b/%0d/%0d want 0/0/0", bus.pix_vali_o, bus.pix_idx_o, bus.bram_addr_o); end
        hits(8'h01, 3);
        n_cmp++; if (bus.destroy_mask_o !== 8'h01) begin n_err++; $display("FAIL look_destroy: got %h want 01", bus.destroy_mask_o); end
        probe(130, 10);
        n_cmp++; if (bus.pix_vali_o !== 1'b1 || bus.pix_idx_o !== 3'd0 || bus.bram_addr_o !== 12'd2530) begin
            n_err++; $display("FAIL look_explode: got %b/%0d/%0d want 1/0/2530", bus.pix_vali_o, bus.pix_idx_o, bus.bram_addr_o); end
    endtask

    task automatic test_clip_reset();
        bit got; int idx; int cyc;
        apply_reset();
        spawn_one(16'd1000, got, idx, cyc);
        bus.en_i = 1'b0;
        frame_ticks(1);
        probe(590, 0);
        n_cmp++; if (bus.pix_vali_o !== 1'b1 || bus.bram_addr_o !== 12'd1950) begin
            n_err++; $display("FAIL clip_left: got %b/%0d want 1/1950", bus.pix_vali_o, bus.bram_addr_o); end
        probe(639, 0);
        n_cmp++; if (bus.pix_vali_o !== 1'b1 || bus.bram_addr_o !== 12'd1999) begin
            n_err++; $display("FAIL clip_right: got %b/%0d want 1/1999", bus.pix_vali_o, bus.bram_addr_o); end
        probe(589, 0);
        n_cmp++; if (bus.pix_vali_o !== 1'b0) begin n_err++; $display("FAIL clip_outside: got %b want 0", bus.pix_vali_o); end
        bus.req_x_i = 10'd590;
        hits(8'h01, 3);
        n_cmp++; if (bus.destroy_mask_o !== 8'h01) begin n_err++; $display("FAIL clip_destroy: got %h want 01", bus.destroy_mask_o); end
        bus.frame_tick_i = 1'b1; step(); bus.frame_tick_i = 1'b0;
        n_cmp++; if (bus.pix_vali_o !== 1'b1 || bus.bram_addr_o !== 12'd3950) begin
            n_err++; $display("FAIL clip_exp_addr: got %b/%0d want 1/3950", bus.pix_vali_o, bus.bram_addr_o); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.pix_vali_o, bus.pix_idx_o, bus.bram_addr_o} !== 16'd0) begin
            n_err++; $display("FAIL async_rst_lookup: got %h want 0", {bus.pix_vali_o, bus.pix_idx_o, bus.bram_addr_o}); end
        n_cmp++; if ({bus.spawn_o, bus.spawn_idx_o, bus.destroy_mask_o, bus.escape_mask_o, bus.alive_o} !== 28'd0) begin
            n_err++; $display("FAIL async_rst_pulses: got %h want 0", {bus.spawn_o, bus.spawn_idx_o, bus.destroy_mask_o, bus.escape_mask_o, bus.alive_o}); end
        n_cmp++; if (bus.active_cnt_o !== 4'd0) begin n_err++; $display("FAIL async_rst_active: got %0d want 0", bus.active_cnt_o); end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_spawn_fill();
        test_slot_reuse();
        test_motion_escape();
        test_kill_vs_escape();
        test_lookup();
        test_clip_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
